// File: rtl/pr2_pkg.sv
// Shared PR2 (ID/EX) layout: field positions, opcode match constants and ctrl bit indices.
// Every PR2 reader and writer imports this so the layout lives in one place.
package pr2_pkg;

    localparam int PR_WIDTH   = 500;

    localparam int INSTR_LSB  = 0;
    localparam int INSTR_MSB  = 31;
    localparam int PC_LSB     = 32;
    localparam int PC_MSB     = 95;
    localparam int RD1_LSB    = 96;
    localparam int RD1_MSB    = 159;
    localparam int RD2_LSB    = 160;
    localparam int RD2_MSB    = 223;
    localparam int RD_LSB     = 224;
    localparam int RD_MSB     = 228;
    localparam int RSV0_LSB   = 229;
    localparam int RSV0_MSB   = 231;
    localparam int IMM_LSB    = 232;
    localparam int IMM_MSB    = 295;
    localparam int CTRL_LSB   = 296;
    localparam int CTRL_MSB   = 305;
    localparam int VALID_BIT  = 306;
    localparam int RSV1_LSB   = 307;

    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [6:0]  OP_CB   = 7'b1011010;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;

    localparam int CTRL_W         = 10;
    localparam int CTRL_REGWRITE  = 0;
    localparam int CTRL_MEMTOREG  = 1;
    localparam int CTRL_MEMWRITE  = 2;
    localparam int CTRL_MEMREAD   = 3;
    localparam int CTRL_UNCOND    = 4;
    localparam int CTRL_BRANCH    = 5;
    localparam int CTRL_ALUSRC    = 6;
    localparam int CTRL_ALUOP_LSB = 7;
    localparam int CTRL_ALUOP_MSB = 8;
    localparam int CTRL_REG2LOC   = 9;

    // EX-stage branch target: the stored immediate is a word offset.
    function automatic logic [63:0] branch_target(input logic [63:0] pc, input logic [63:0] imm);
        return pc + {imm[61:0], 2'b00};
    endfunction

endpackage

// File: rtl/imm_sign_extend.sv
// Combinational immediate extraction for the decode stage: picks and extends the
// immediate field by instruction format; result is an unshifted word/byte offset.
module imm_sign_extend (
    input  logic [31:0] instr,
    output logic [63:0] imm
);
    import pr2_pkg::*;

    logic signed [25:0] b_off;
    logic signed [18:0] cb_off;
    logic signed [8:0]  d_off;
    logic        [11:0] i_imm;

    assign b_off  = instr[25:0];
    assign cb_off = instr[23:5];
    assign d_off  = instr[20:12];
    assign i_imm  = instr[21:10];

    // Arithmetic immediates are unsigned; all address offsets are two's complement.
    always_comb begin
        imm = 64'h0;
        if (instr[31:26] == OP_B)
            imm = 64'(b_off);
        else if (instr[31:25] == OP_CB)
            imm = 64'(cb_off);
        else if (instr[31:21] == OP_LDUR || instr[31:21] == OP_STUR)
            imm = 64'(d_off);
        else if (instr[31:22] == OP_ADDI || instr[31:22] == OP_SUBI)
            imm = {52'h0, i_imm};
    end

endmodule

// File: rtl/id_ex_pipeline_writer.sv
// Writer side of the ID/EX (PR2) register: packs decode fields, then registers them
// with flush > stall > load priority and counts every bubble it inserts.
module id_ex_pipeline_writer #(
    parameter int PR_WIDTH  = 500,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [31:0]          instr,
    input  logic [63:0]          pc,
    input  logic [63:0]          rd1,
    input  logic [63:0]          rd2,
    input  logic [9:0]           ctrl,
    input  logic                 stall,
    input  logic                 flush,
    output logic [PR_WIDTH-1:0]  PR2,
    output logic [CNT_WIDTH-1:0] bubble_cnt
);
    import pr2_pkg::*;

    logic [63:0]          imm_p0;
    logic [PR_WIDTH-1:0]  pr2_p0;
    logic [PR_WIDTH-1:0]  pr2_p1;
    logic [CNT_WIDTH-1:0] bubble_cnt_q;

    imm_sign_extend u_imm_sign_extend (
        .instr (instr),
        .imm   (imm_p0)
    );

    // Stage p0: combinational pack; reserved ranges stay at the zero default.
    always_comb begin
        pr2_p0                      = '0;
        pr2_p0[INSTR_MSB:INSTR_LSB] = instr;
        pr2_p0[PC_MSB:PC_LSB]       = pc;
        pr2_p0[RD1_MSB:RD1_LSB]     = rd1;
        pr2_p0[RD2_MSB:RD2_LSB]     = rd2;
        pr2_p0[RD_MSB:RD_LSB]       = instr[4:0];
        pr2_p0[IMM_MSB:IMM_LSB]     = imm_p0;
        pr2_p0[CTRL_MSB:CTRL_LSB]   = ctrl;
        pr2_p0[VALID_BIT]           = 1'b1;
    end

    // Stage p1: the PR2 register. Flush beats stall so a flushed slot never keeps stale data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pr2_p1       <= '0;
            bubble_cnt_q <= '0;
        end else if (flush) begin
            pr2_p1       <= '0;
            bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
        end else if (stall) begin
            pr2_p1       <= pr2_p1;
            bubble_cnt_q <= bubble_cnt_q;
        end else if (in_valid) begin
            pr2_p1       <= pr2_p0;
        end else begin
            pr2_p1       <= '0;
            bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
        end
    end

    assign PR2        = pr2_p1;
    assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_pipeline_writer.sv
// Scoreboard bench for id_ex_pipeline_writer: driver pushes model expectations,
// a monitor pops and compares one entry after each rising edge.
module tb_id_ex_pipeline_writer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, stall, flush;
    logic [31:0]  instr;
    logic [63:0]  pc, rd1, rd2;
    logic [9:0]   ctrl;
    logic [499:0] PR2;
    logic [15:0]  bubble_cnt;

    id_ex_pipeline_writer #(.PR_WIDTH(500), .CNT_WIDTH(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .instr      (instr),
        .pc         (pc),
        .rd1        (rd1),
        .rd2        (rd2),
        .ctrl       (ctrl),
        .stall      (stall),
        .flush      (flush),
        .PR2        (PR2),
        .bubble_cnt (bubble_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [499:0] pr2;
        logic [15:0]  cnt;
    } exp_t;

    exp_t         sb_q[$];
    logic [499:0] m_pr2;
    int           m_cnt;
    int           vectors = 0;
    int           miscompares = 0;

    task automatic chk(input string name, input logic [499:0] act, input logic [499:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference immediate from the format rules, using integer ranges for sign.
    function automatic logic [63:0] model_imm(input logic [31:0] i);
        longint v;
        if (i[31:26] == 6'b000101) begin
            v = longint'(i[25:0]);
            if (v >= 64'sd33554432) v = v - 64'sd67108864;
        end else if (i[31:25] == 7'b1011010) begin
            v = longint'(i[23:5]);
            if (v >= 64'sd262144) v = v - 64'sd524288;
        end else if (i[31:21] == 11'b11111000010 || i[31:21] == 11'b11111000000) begin
            v = longint'(i[20:12]);
            if (v >= 64'sd256) v = v - 64'sd512;
        end else if (i[31:22] == 10'b1001000100 || i[31:22] == 10'b1101000100) begin
            v = longint'(i[21:10]);
        end else begin
            v = 0;
        end
        return 64'(v);
    endfunction

    function automatic logic [499:0] model_pack(input logic [31:0] i, input logic [63:0] p,
                                                input logic [63:0] r1, input logic [63:0] r2,
                                                input logic [9:0] c);
        logic [499:0] w = '0;
        w[31:0]    = i;
        w[95:32]   = p;
        w[159:96]  = r1;
        w[223:160] = r2;
        w[228:224] = i[4:0];
        w[295:232] = model_imm(i);
        w[305:296] = c;
        w[306]     = 1'b1;
        return w;
    endfunction

    task automatic step(input logic fl, input logic st, input logic iv, input logic [31:0] i,
                        input logic [63:0] p, input logic [63:0] r1, input logic [63:0] r2,
                        input logic [9:0] c);
        exp_t e;
        @(negedge clk);
        flush = fl; stall = st; in_valid = iv;
        instr = i; pc = p; rd1 = r1; rd2 = r2; ctrl = c;
        if (fl) begin
            m_pr2 = '0;
            m_cnt = (m_cnt + 1) % 65536;
        end else if (st) begin
            m_pr2 = m_pr2;
        end else if (iv) begin
            m_pr2 = model_pack(i, p, r1, r2, c);
        end else begin
            m_pr2 = '0;
            m_cnt = (m_cnt + 1) % 65536;
        end
        e.pr2 = m_pr2;
        e.cnt = 16'(m_cnt);
        sb_q.push_back(e);
    endtask

    task automatic rand_step(input int fl_pct, input int st_pct);
        logic [31:0] i;
        i = $urandom;
        case ($urandom_range(0, 4))
            0: i[31:26] = 6'b000101;
            1: i[31:25] = 7'b1011010;
            2: i[31:21] = ($urandom_range(0, 1) != 0) ? 11'b11111000010 : 11'b11111000000;
            3: i[31:22] = ($urandom_range(0, 1) != 0) ? 10'b1001000100 : 10'b1101000100;
            default: ;
        endcase
        step($urandom_range(0, 99) < fl_pct, $urandom_range(0, 99) < st_pct,
             $urandom_range(0, 99) < 75, i, {$urandom, $urandom}, {$urandom, $urandom},
             {$urandom, $urandom}, 10'($urandom));
    endtask

    // Asynchronous reset asserted between edges while stalling and flushing.
    task automatic do_reset;
        @(posedge clk);
        #3;
        stall = 1'b1;
        flush = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_pr2", PR2, '0);
        chk("async_rst_cnt", {484'h0, bubble_cnt}, '0);
        m_pr2 = '0;
        m_cnt = 0;
        @(posedge clk);
        #1;
        chk("rst_hold_pr2", PR2, '0);
        @(posedge clk);
        #3;
        stall = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_pr2", PR2, e.pr2);
                chk("sb_cnt", {484'h0, bubble_cnt}, {484'h0, e.cnt});
            end
        end
    end

    initial begin : driver
        logic [499:0] word_a;
        logic [63:0]  tgt;
        logic [15:0]  cnt0;

        rst_n = 1'b0; in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
        instr = '0; pc = '0; rd1 = '0; rd2 = '0; ctrl = '0;
        m_pr2 = '0; m_cnt = 0;
        #2;
        chk("reset_pr2", PR2, '0);
        chk("reset_cnt", {484'h0, bubble_cnt}, '0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;

        // CBZ with offset -2 words
        step(0, 0, 1, 32'hB4FFFFC0, 64'h100, 64'h11, 64'h22, 10'h2A1);
        @(posedge clk); #2;
        chk("cbz_imm", {436'h0, PR2[295:232]}, {436'h0, 64'hFFFF_FFFF_FFFF_FFFE});
        chk("cbz_pc", {436'h0, PR2[95:32]}, {436'h0, 64'h100});
        chk("cbz_valid", {499'h0, PR2[306]}, {499'h0, 1'b1});
        tgt = PR2[95:32] + (PR2[295:232] << 2);
        chk("cbz_target", {436'h0, tgt}, {436'h0, 64'hF8});

        step(0, 0, 1, {6'b000101, 26'h0000010}, 64'h2000, 64'h0, 64'h0, 10'h010);
        @(posedge clk); #2;
        chk("b_imm", {436'h0, PR2[295:232]}, {436'h0, 64'h10});
        tgt = PR2[95:32] + (PR2[295:232] << 2);
        chk("b_target", {436'h0, tgt}, {436'h0, 64'h2040});

        step(0, 0, 1, {11'b11111000010, 9'h1F0, 2'b00, 5'd1, 5'd2}, 64'h3000, 64'h5, 64'h6, 10'h0CB);
        @(posedge clk); #2;
        chk("ldur_imm", {436'h0, PR2[295:232]}, {436'h0, 64'hFFFF_FFFF_FFFF_FFF0});

        // Stall holds word A for three cycles while inputs change
        step(0, 0, 1, {10'b1001000100, 12'hABC, 5'd3, 5'd4}, 64'h4000, 64'hA1, 64'hA2, 10'h0C1);
        word_a = model_pack({10'b1001000100, 12'hABC, 5'd3, 5'd4}, 64'h4000, 64'hA1, 64'hA2, 10'h0C1);
        cnt0 = 16'(m_cnt);
        for (int k = 0; k < 3; k++)
            step(0, 1, 1, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, 64'h0, 10'($urandom));
        @(posedge clk); #2;
        chk("stall_hold", PR2, word_a);
        chk("stall_cnt", {484'h0, bubble_cnt}, {484'h0, cnt0});

        step(1, 1, 1, 32'h8B020020, 64'h5000, 64'h1, 64'h2, 10'h3FF);
        step(0, 0, 0, 32'h8B020020, 64'h5004, 64'h1, 64'h2, 10'h3FF);
        @(posedge clk); #2;
        chk("flush_stall_pr2", PR2, '0);
        chk("bubble_plus2", {484'h0, bubble_cnt}, {484'h0, 16'(cnt0 + 16'd2)});

        // Reset while loaded, then the first load lands one edge after release
        step(0, 0, 1, 32'h91000421, 64'h6000, 64'h7, 64'h8, 10'h0C1);
        do_reset();
        step(0, 0, 1, 32'hF8408022, 64'h7000, 64'h9, 64'hA, 10'h0CB);

        for (int k = 0; k < 1500; k++)
            rand_step(10, 20);

        // Counter wrap: 65535 flushes from zero, then one more
        do_reset();
        for (int k = 0; k < 65535; k++)
            step(1, 0, 0, 32'h0, 64'h0, 64'h0, 64'h0, 10'h0);
        @(posedge clk); #2;
        chk("cnt_ffff", {484'h0, bubble_cnt}, {484'h0, 16'hFFFF});
        step(1, 0, 1, 32'h0, 64'h0, 64'h0, 64'h0, 10'h0);
        @(posedge clk); #2;
        chk("cnt_wrap", {484'h0, bubble_cnt}, {484'h0, 16'h0000});

        for (int k = 0; k < 200; k++)
            rand_step(5, 15);

        @(negedge clk);
        flush = 1'b0; stall = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        if (sb_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL sb_drain: %0d entries left, 0 required", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
